// File: rtl/geofence_poly_pkg.sv
// Shared types and width helpers for the polygon geofence: point storage,
// FSM state encoding and the signed arithmetic widths derived from WIDTH.
package geofence_poly_pkg;

   // Widest coordinate supported; narrower coordinates are stored zero-extended.
   localparam int MAX_W = 16;

   typedef struct packed {
      logic [MAX_W-1:0] x;
      logic [MAX_W-1:0] y;
   } point_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      CHECK = 2'd2,
      OUT   = 2'd3
   } state_t;

   function automatic int diff_w(input int w);
      return w + 1;
   endfunction

   function automatic int prod_w(input int w);
      return 2 * w + 2;
   endfunction

   function automatic int cross_w(input int w);
      return 2 * w + 3;
   endfunction

   function automatic logic signed [MAX_W:0] pt_dx(input point_t a, input point_t b);
      return $signed({1'b0, a.x}) - $signed({1'b0, b.x});
   endfunction

   function automatic logic signed [MAX_W:0] pt_dy(input point_t a, input point_t b);
      return $signed({1'b0, a.y}) - $signed({1'b0, b.y});
   endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed 2-D cross product a x b = ax*by - ay*bx, exact width.
module geofence_cross
   import geofence_poly_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic signed [WIDTH:0]            ax_i,
   input  logic signed [WIDTH:0]            ay_i,
   input  logic signed [WIDTH:0]            bx_i,
   input  logic signed [WIDTH:0]            by_i,
   output logic signed [cross_w(WIDTH)-1:0] c_o
);

   localparam int PW  = prod_w(WIDTH);
   localparam int CRW = cross_w(WIDTH);

   logic signed [PW-1:0] p_ab;
   logic signed [PW-1:0] p_ba;

   assign p_ab = PW'(ax_i) * PW'(by_i);
   assign p_ba = PW'(ay_i) * PW'(bx_i);
   assign c_o  = CRW'(p_ab) - CRW'(p_ba);

endmodule

// File: rtl/geofence_poly.sv
// Point-in-convex-polygon test: load object + vertices, angle-sort vertices
// about V0 with a fixed-length bubble sort, then test the object against every edge.
module geofence_poly
   import geofence_poly_pkg::*;
#(
   parameter int NPOINT      = 6,
   parameter int WIDTH       = 10,
   parameter bit EDGE_INSIDE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             valid,
   output logic             is_inside
);

   localparam int DW  = diff_w(WIDTH);
   localparam int CRW = cross_w(WIDTH);
   localparam int IW  = $clog2(NPOINT);
   localparam int CW  = $clog2(NPOINT + 1);

   localparam logic [IW-1:0] PIVOT    = '0;
   localparam logic [IW-1:0] LAST_IDX = IW'(NPOINT - 1);
   localparam logic [IW-1:0] SORT_END = IW'(NPOINT - 2);
   localparam logic [IW-1:0] PASS_END = IW'(NPOINT - 3);
   localparam logic [CW-1:0] LOAD_END = CW'(NPOINT);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d, idx_n;
   logic [IW-1:0]   pass_q, pass_d;
   logic            pos_q, pos_d, neg_q, neg_d, zero_q, zero_d;

   point_t          vert_q [NPOINT];
   point_t          obj_q;
   point_t          pt_in, pa, pb, base;
   logic signed [DW-1:0]  ax, ay, bx, by;
   logic signed [CRW-1:0] cross_c;
   logic            swap;
   logic            inside_w;

   // SORT compares (V[i]-V0, V[i+1]-V0); CHECK uses (V[k+1]-V[k], OBJ-V[k]).
   always_comb begin
      pt_in.x = MAX_W'(X);
      pt_in.y = MAX_W'(Y);
      idx_n   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      if (state_q == SORT) begin
         pa   = vert_q[idx_q];
         pb   = vert_q[idx_n];
         base = vert_q[PIVOT];
      end else begin
         pa   = vert_q[idx_n];
         pb   = obj_q;
         base = vert_q[idx_q];
      end
      ax   = DW'(pt_dx(pa, base));
      ay   = DW'(pt_dy(pa, base));
      bx   = DW'(pt_dx(pb, base));
      by   = DW'(pt_dy(pb, base));
      swap = (state_q == SORT) && cross_c[CRW-1];
   end

   geofence_cross #(.WIDTH(WIDTH)) u_cross (
      .ax_i (ax),
      .ay_i (ay),
      .bx_i (bx),
      .by_i (by),
      .c_o  (cross_c)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      pos_d   = pos_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      case (state_q)
         LOAD: begin
            if (cnt_q == LOAD_END) begin
               state_d = SORT;
               cnt_d   = '0;
               idx_d   = IW'(1);
               pass_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SORT: begin
            if (idx_q == SORT_END) begin
               idx_d = IW'(1);
               if (pass_q == PASS_END) begin
                  state_d = CHECK;
                  idx_d   = '0;
                  pos_d   = 1'b0;
                  neg_d   = 1'b0;
                  zero_d  = 1'b0;
               end else begin
                  pass_d = pass_q + IW'(1);
               end
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         CHECK: begin
            pos_d  = pos_q  | (!cross_c[CRW-1] && (cross_c != '0));
            neg_d  = neg_q  | cross_c[CRW-1];
            zero_d = zero_q | (cross_c == '0);
            idx_d  = idx_n;
            if (idx_q == LAST_IDX) state_d = OUT;
         end
         OUT: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         idx_q   <= '0;
         pass_q  <= '0;
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
      end
   end

   // Point storage carries no reset; a fresh set always overwrites it in LOAD.
   always_ff @(posedge clk) begin
      if (state_q == LOAD) begin
         if (cnt_q == '0) obj_q <= pt_in;
         else             vert_q[IW'(cnt_q - CW'(1))] <= pt_in;
      end else if (swap) begin
         vert_q[idx_q] <= vert_q[idx_n];
         vert_q[idx_n] <= vert_q[idx_q];
      end
   end

   assign inside_w  = !(pos_q && neg_q) && (zero_q ? EDGE_INSIDE : 1'b1);
   assign valid     = (state_q == OUT);
   assign is_inside = valid && inside_w;

endmodule

// File: tb/tb_geofence_poly.sv
// Directed and geometry-modelled checks of geofence_poly: two NPOINT=6 instances
// (edge classified outside / inside) sharing stimulus, plus an NPOINT=3 instance.
module tb_geofence_poly;

   logic       clk = 1'b0;
   logic       reset, reset3;
   logic [9:0] X, Y, X3, Y3;
   logic       valid_a, in_a, valid_b, in_b, valid_c, in_c;

   int total = 0;
   int bad   = 0;
   int sx [7];
   int sy [7];

   always #5 clk = ~clk;

   geofence_poly #(.NPOINT(6), .WIDTH(10), .EDGE_INSIDE(1'b0)) dut_a (
      .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid_a), .is_inside(in_a));
   geofence_poly #(.NPOINT(6), .WIDTH(10), .EDGE_INSIDE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid_b), .is_inside(in_b));
   geofence_poly #(.NPOINT(3), .WIDTH(10), .EDGE_INSIDE(1'b0)) dut_c (
      .clk(clk), .reset(reset3), .X(X3), .Y(Y3), .valid(valid_c), .is_inside(in_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_hex(input int ox, input int oy);
      sx[0] = ox;  sy[0] = oy;
      sx[1] = 100; sy[1] = 0;
      sx[2] = 200; sy[2] = 0;
      sx[3] = 250; sy[3] = 100;
      sx[4] = 200; sy[4] = 200;
      sx[5] = 100; sy[5] = 200;
      sx[6] = 50;  sy[6] = 100;
   endtask

   task automatic set_shuffled(input int ox, input int oy);
      sx[0] = ox;  sy[0] = oy;
      sx[1] = 200; sy[1] = 200;
      sx[2] = 100; sy[2] = 0;
      sx[3] = 50;  sy[3] = 100;
      sx[4] = 250; sy[4] = 100;
      sx[5] = 100; sy[5] = 200;
      sx[6] = 200; sy[6] = 0;
   endtask

   task automatic load_set();
      for (int p = 0; p < 7; p++) begin
         X = 10'(sx[p]);
         Y = 10'(sy[p]);
         tick();
      end
   endtask

   // Loads sx/sy, expects valid only in the 23rd cycle after the last-vertex edge.
   task automatic run6(input string name, input bit exp_a, input bit exp_b);
      bit early;
      early = 1'b0;
      load_set();
      for (int n = 1; n <= 22; n++) begin
         if (valid_a || in_a || valid_b || in_b) early = 1'b1;
         X = 10'($urandom);
         Y = 10'($urandom);
         tick();
      end
      total++;
      if (early !== 1'b0) begin
         bad++;
         $display("FAIL %s early_out: output high before cycle 23, want low", name);
      end
      total++;
      if (valid_a !== 1'b1) begin
         bad++;
         $display("FAIL %s valid_a: got %b want 1", name, valid_a);
      end
      total++;
      if (in_a !== exp_a) begin
         bad++;
         $display("FAIL %s inside_a: got %b want %b", name, in_a, exp_a);
      end
      total++;
      if (valid_b !== 1'b1) begin
         bad++;
         $display("FAIL %s valid_b: got %b want 1", name, valid_b);
      end
      total++;
      if (in_b !== exp_b) begin
         bad++;
         $display("FAIL %s inside_b: got %b want %b", name, in_b, exp_b);
      end
      tick();
      total++;
      if ({valid_a, in_a, valid_b, in_b} !== 4'b0000) begin
         bad++;
         $display("FAIL %s pulse_end: got %b want 0000", name, {valid_a, in_a, valid_b, in_b});
      end
   endtask

   task automatic run3(input string name, input int ox, input int oy, input bit exp_in);
      int tx [4];
      int ty [4];
      bit early;
      tx[0] = ox; ty[0] = oy;
      tx[1] = 0;    ty[1] = 0;
      tx[2] = 1023; ty[2] = 0;
      tx[3] = 0;    ty[3] = 1023;
      early = 1'b0;
      for (int p = 0; p < 4; p++) begin
         X3 = 10'(tx[p]);
         Y3 = 10'(ty[p]);
         tick();
      end
      for (int n = 1; n <= 4; n++) begin
         if (valid_c || in_c) early = 1'b1;
         tick();
      end
      total++;
      if (early !== 1'b0) begin
         bad++;
         $display("FAIL %s early_out: output high before cycle 5, want low", name);
      end
      total++;
      if (valid_c !== 1'b1) begin
         bad++;
         $display("FAIL %s valid_c: got %b want 1", name, valid_c);
      end
      total++;
      if (in_c !== exp_in) begin
         bad++;
         $display("FAIL %s inside_c: got %b want %b", name, in_c, exp_in);
      end
      tick();
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      reset3 = 1'b1;
      X = '0; Y = '0; X3 = '0; Y3 = '0;
      tick();
      tick();
      total++;
      if ({valid_a, in_a, valid_b, in_b, valid_c, in_c} !== 6'b0) begin
         bad++;
         $display("FAIL reset_out: got %b want 000000",
                  {valid_a, in_a, valid_b, in_b, valid_c, in_c});
      end
      reset = 1'b0;
   endtask

   task automatic test_hexagon();
      set_hex(150, 100);
      run6("hex_center", 1'b1, 1'b1);
   endtask

   task automatic test_shuffled();
      set_shuffled(300, 100);
      run6("shuf_outside", 1'b0, 1'b0);
      set_shuffled(150, 100);
      run6("shuf_center", 1'b1, 1'b1);
   endtask

   task automatic test_edge();
      set_hex(150, 0);
      run6("edge_bottom", 1'b0, 1'b1);
      set_shuffled(100, 200);
      run6("edge_vertex", 1'b0, 1'b1);
   endtask

   task automatic abort_at(input string name, input int busy);
      bit seen;
      seen = 1'b0;
      set_hex(300, 100);
      load_set();
      for (int n = 0; n < busy; n++) begin
         if (valid_a || valid_b) seen = 1'b1;
         tick();
      end
      reset = 1'b1;
      tick();
      total++;
      if (seen || ({valid_a, in_a, valid_b, in_b} !== 4'b0000)) begin
         bad++;
         $display("FAIL %s abort: got seen=%b out=%b want 0/0000", name, seen,
                  {valid_a, in_a, valid_b, in_b});
      end
      reset = 1'b0;
      set_hex(150, 100);
      run6(name, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      abort_at("abort_sort", 5);
      abort_at("abort_check", 19);
   endtask

   // Hexagon (cx+-a,cy+-b),(cx+-2a,cy): inside iff |dy|<b and b|dx|+a|dy|<2ab.
   task automatic test_back_to_back();
      int a, b, cx, cy, ox, oy, dx, dy, lhs, lim, j, t;
      bit ea, eb;
      for (int s = 0; s < 50; s++) begin
         a  = int'($urandom_range(100, 1));
         b  = int'($urandom_range(200, 1));
         cx = int'($urandom_range(1023 - 2 * a, 2 * a));
         cy = int'($urandom_range(1023 - b, b));
         sx[1] = cx - a;     sy[1] = cy - b;
         sx[2] = cx + a;     sy[2] = cy - b;
         sx[3] = cx + 2 * a; sy[3] = cy;
         sx[4] = cx + a;     sy[4] = cy + b;
         sx[5] = cx - a;     sy[5] = cy + b;
         sx[6] = cx - 2 * a; sy[6] = cy;
         for (int i = 6; i > 1; i--) begin
            j = int'($urandom_range(i, 1));
            t = sx[i]; sx[i] = sx[j]; sx[j] = t;
            t = sy[i]; sy[i] = sy[j]; sy[j] = t;
         end
         if (s % 5 == 0) begin
            ox = cx + int'($urandom_range(2 * a, 0)) - a;
            oy = cy + b;
         end else begin
            ox = int'($urandom_range((cx + 2 * a + 10 > 1023) ? 1023 : cx + 2 * a + 10,
                                     (cx - 2 * a - 10 < 0) ? 0 : cx - 2 * a - 10));
            oy = int'($urandom_range((cy + b + 10 > 1023) ? 1023 : cy + b + 10,
                                     (cy - b - 10 < 0) ? 0 : cy - b - 10));
         end
         dx  = (ox > cx) ? ox - cx : cx - ox;
         dy  = (oy > cy) ? oy - cy : cy - oy;
         lhs = b * dx + a * dy;
         lim = 2 * a * b;
         if (dy < b && lhs < lim) begin
            ea = 1'b1; eb = 1'b1;
         end else if (dy <= b && lhs <= lim) begin
            ea = 1'b0; eb = 1'b1;
         end else begin
            ea = 1'b0; eb = 1'b0;
         end
         sx[0] = ox; sy[0] = oy;
         run6($sformatf("rand%0d", s), ea, eb);
      end
   endtask

   task automatic test_triangle();
      reset3 = 1'b0;
      run3("tri_inside", 1, 1, 1'b1);
      run3("tri_outside", 600, 600, 1'b0);
   endtask

   initial begin
      test_reset();
      test_hexagon();
      test_shuffled();
      test_edge();
      test_reset_mid();
      test_back_to_back();
      test_triangle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
